// File: rtl/restador_serie_n_bits.sv
// Bit-serial N-bit subtractor (d = x - y, LSB first) built around one full-subtractor cell.
// Optional signed-overflow output enabled by defining RESTADOR_SERIE_OVF_EN.

module restador_completo_1_bit (
  input  logic x_i,
  input  logic y_i,
  input  logic b_in_i,
  output logic d_o,
  output logic b_out_o
);

  assign d_o     = x_i ^ y_i ^ b_in_i;
  assign b_out_o = (~x_i & y_i) | (~(x_i ^ y_i) & b_in_i);

endmodule

module restador_serie_n_bits #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] d_o,
  output logic         b_out_o
`ifdef RESTADOR_SERIE_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q;
  logic [N-1:0]  sx_q;
  logic [N-1:0]  sy_q;
  logic [N-1:0]  sd_q;
  logic [N-1:0]  sd_d;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          bOut_q;
  logic          busy_q;
  logic          done_q;
  logic          cellD;
  logic          cellBout;
  logic          lastBit;

  restador_completo_1_bit u_cell (
    .x_i     (sx_q[0]),
    .y_i     (sy_q[0]),
    .b_in_i  (br_q),
    .d_o     (cellD),
    .b_out_o (cellBout)
  );

  assign sd_d    = {cellD, sd_q[N-1:1]};
  assign lastBit = (cnt_q == LAST);

`ifdef RESTADOR_SERIE_OVF_EN
  // Borrow into the MSB, kept so ovf can be formed from two held flops.
  logic brMsb_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      sd_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bOut_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RESTADOR_SERIE_OVF_EN
      brMsb_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sx_q    <= x_i;
            sy_q    <= y_i;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sd_q  <= sd_d;
          br_q  <= cellBout;
          sx_q  <= {1'b0, sx_q[N-1:1]};
          sy_q  <= {1'b0, sy_q[N-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (lastBit) begin
            // Publish on the edge that processes the MSB, not one cycle later.
            d_q     <= sd_d;
            bOut_q  <= cellBout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef RESTADOR_SERIE_OVF_EN
            brMsb_q <= br_q;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign d_o     = d_q;
  assign b_out_o = bOut_q;
`ifdef RESTADOR_SERIE_OVF_EN
  assign ovf_o   = brMsb_q ^ bOut_q;
`endif

endmodule
